keysw_responder: RTL
====================

# keysw_responder

Memory-mapped input responder for the push-buttons (KEY) and slide switches (SW). It answers processor loads and stores at the KEY/SW data and control addresses. It synchronizes and debounces the raw pins and latches a sticky Ready/Overrun status per device, so software can poll for input events instead of sampling levels. It sits beside the UI output controller on the IO bus and drives the read-data path that feeds register-file writeback.

## Interface
Parameters:
- `DBITS`, 32: bus data/address width.
- `ADDR_KDATA`, 32'hF0000010: KEY data register (read-only).
- `ADDR_SDATA`, 32'hF0000014: SW data register (read-only).
- `ADDR_KCTRL`, 32'hF0000110: KEY control/status register.
- `ADDR_SCTRL`, 32'hF0000114: SW control/status register.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a switch change is accepted. Must be ≥2.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `addr` in DBITS: bus address.
- `wrData` in DBITS: store data.
- `wrEn` in 1: store strobe, one cycle per store.
- `rdEn` in 1: load strobe, one cycle per load.
- `rdData` out DBITS: load data. Combinational from `addr`; 0 when no hit.
- `hit` out 1: `addr` equals one of the four register addresses.
- `irq` out 1: interrupt request. Constant 0 unless configured.
- `KEY` in 4: raw buttons, active-low.
- `SW` in 10: raw switches.

## Operation
- **KEY path:** 2-flop synchronizer with reset value 4'hF, giving `kSync`. `KDATA` = {28'b0, ~kSync}, registered, so 1 means pressed. No debounce.
- **SW path:** 2-flop synchronizer with reset value 0, giving `sSync`. Each bit has a debounce counter of width clog2(DEBOUNCE_CYCLES):
  - The counter clears whenever the bit's `sSync` equals `sDeb`.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1 and the bit still differs, `sDeb` takes `sSync` and the counter clears.
  - `SDATA` = {22'b0, sDeb}.
- **Events:** a KEY event is any edge where the next `KDATA` differs from the current one. A SW event is any edge where any `sDeb` bit updates.
- **Control/status register layout (KCTRL/SCTRL):**
  - bit0 Ready: set on an event.
  - bit2 Overrun: set on an event while Ready is already 1.
  - All other bits read 0.
- **Load of KDATA/SDATA** (`rdEn` & address match): clears that device's Ready at the edge.
- **Store to KCTRL/SCTRL:**
  - `wrData[2]`=0 clears Overrun; `wrData[2]`=1 leaves it unchanged.
  - bit0 is ignored.
  - Stores to KDATA/SDATA are ignored.
- **Same-edge event and data load:** Ready stays 1 and Overrun is not set.
- **Same-edge event and Overrun-clearing store:** Overrun ends at 1 (set wins).
- **Load of a CTRL register:** no side effects.
- **Asserting `reset_n` low mid-debounce:** counters, `sDeb`, and status bits clear immediately.
- **Reset values:** `KDATA`=0, `SDATA`=0, all Ready/Overrun=0, `irq`=0. `rdData`=0 for any non-hit address.
- Switches already up at reset produce one SW event after the debounce time. This is intended.

## Timing
- `rdData` and `hit` are combinational, with zero-cycle load latency, matching single-cycle writeback.
- **KEY pin change:** `KDATA` and Ready update on the 3rd rising edge after the change (2 sync edges + 1 register edge).
- **SW pin change held stable:** `SDATA` and Ready update on the (2+DEBOUNCE_CYCLES)th edge.
- **SW glitch:** a glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes `SDATA`.
- **Status side effects:** take effect at the edge where the strobe is sampled and are visible to the next cycle's load.

## Configuration
- `KEYSW_IRQ_EN` defined:
  - bit8 of KCTRL/SCTRL is an Interrupt Enable. It is read/write via stores and resets to 0.
  - `irq` = (kReady & kIE) | (sReady & sIE), registered, asserting one cycle after the qualifying state.
- `KEYSW_IRQ_EN` undefined:
  - bit8 reads 0 and writes to it are ignored.
  - `irq` is tied to 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `reset_n`=0 with KEY=4'hF and SW=0, release, load 0xF0000010 and 0xF0000110. Required: `rdData`=0 for both and `irq`=0.
- **Key press:** drive KEY=4'b1110. Required: the 3rd edge shows KDATA=1 and KCTRL=1. Loading KDATA returns 1, and the next KCTRL load returns 0.
- **Overrun:** press KEY0, then KEY1 without reading. Required: KCTRL=5. Storing 0 to KCTRL gives KCTRL=1.
- **SW debounce:** pulse SW[3] high for 3 cycles. Required: SDATA stays 0. Then hold it high. Required: SDATA=8 on edge 6 and SCTRL bit0=1.
- **Simultaneous:** a KEY event on the same edge as a KDATA load. Required: Ready=1 and Overrun=0 afterwards.
- **Interrupt (`KEYSW_IRQ_EN`):** store 0x100 to KCTRL, then press a key. Required: `irq`=1 one cycle after Ready, and `irq`=0 one cycle after the KDATA load.

Source files
------------

// File: rtl/keysw_responder.sv
// KEY/SW memory-mapped input responder: sync, debounce, sticky Ready/Overrun.
// Define KEYSW_IRQ_EN to add per-device interrupt enables and the irq output.
module keysw_responder #(
    parameter int                DBITS           = 32,
    parameter logic [DBITS-1:0]  ADDR_KDATA      = 'hF0000010,
    parameter logic [DBITS-1:0]  ADDR_SDATA      = 'hF0000014,
    parameter logic [DBITS-1:0]  ADDR_KCTRL      = 'hF0000110,
    parameter logic [DBITS-1:0]  ADDR_SCTRL      = 'hF0000114,
    parameter int                DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrData,
    input  logic             wrEn,
    input  logic             rdEn,
    output logic [DBITS-1:0] rdData,
    output logic             hit,
    output logic             irq,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    k_meta;
    logic [3:0]    k_sync;
    logic [3:0]    k_data;
    logic [9:0]    s_meta;
    logic [9:0]    s_sync;
    logic [9:0]    s_deb;
    logic [9:0]    s_upd;
    logic [CW-1:0] s_cnt [10];

    logic k_ready, k_ovr, k_ie;
    logic s_ready, s_ovr, s_ie;
    logic k_ready_n, k_ovr_n;
    logic s_ready_n, s_ovr_n;

    logic hit_kd, hit_sd, hit_kc, hit_sc;
    logic k_load, s_load, k_store, s_store;
    logic k_event, s_event;
    logic unused_wr;

    assign hit_kd = (addr == ADDR_KDATA);
    assign hit_sd = (addr == ADDR_SDATA);
    assign hit_kc = (addr == ADDR_KCTRL);
    assign hit_sc = (addr == ADDR_SCTRL);
    assign hit    = hit_kd | hit_sd | hit_kc | hit_sc;

    assign k_load  = rdEn & hit_kd;
    assign s_load  = rdEn & hit_sd;
    assign k_store = wrEn & hit_kc;
    assign s_store = wrEn & hit_sc;

    assign unused_wr = ^wrData;

    // Buttons are active-low at the pin; synchronizer idles at released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_meta <= 4'hF;
            k_sync <= 4'hF;
            k_data <= 4'h0;
            s_meta <= '0;
            s_sync <= '0;
        end else begin
            k_meta <= KEY;
            k_sync <= k_meta;
            k_data <= ~k_sync;
            s_meta <= SW;
            s_sync <= s_meta;
        end
    end

    assign k_event = (~k_sync != k_data);

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            s_upd[i] = (s_sync[i] != s_deb[i]) && (s_cnt[i] == CNT_MAX);
        end
    end

    assign s_event = |s_upd;

    // A bit is accepted only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_deb <= '0;
            for (int i = 0; i < 10; i++) begin
                s_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (s_sync[i] == s_deb[i]) begin
                    s_cnt[i] <= '0;
                end else if (s_upd[i]) begin
                    s_deb[i] <= s_sync[i];
                    s_cnt[i] <= '0;
                end else begin
                    s_cnt[i] <= s_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Event beats a same-edge data load; overrun set beats a clearing store.
    always_comb begin
        k_ready_n = k_event | (k_ready & ~k_load);
        k_ovr_n   = (k_event & k_ready & ~k_load)
                  | (k_ovr & ~(k_store & ~wrData[2]));
        s_ready_n = s_event | (s_ready & ~s_load);
        s_ovr_n   = (s_event & s_ready & ~s_load)
                  | (s_ovr & ~(s_store & ~wrData[2]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_ready <= 1'b0;
            k_ovr   <= 1'b0;
            s_ready <= 1'b0;
            s_ovr   <= 1'b0;
        end else begin
            k_ready <= k_ready_n;
            k_ovr   <= k_ovr_n;
            s_ready <= s_ready_n;
            s_ovr   <= s_ovr_n;
        end
    end

`ifdef KEYSW_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_ie  <= 1'b0;
            s_ie  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (k_store) begin
                k_ie <= wrData[8];
            end
            if (s_store) begin
                s_ie <= wrData[8];
            end
            irq_q <= (k_ready & k_ie) | (s_ready & s_ie);
        end
    end

    assign irq = irq_q;
`else
    assign k_ie = 1'b0;
    assign s_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    function automatic logic [DBITS-1:0] ctrl_word(
        input logic ready,
        input logic ovr,
        input logic ie
    );
        logic [DBITS-1:0] w;
        w    = '0;
        w[0] = ready;
        w[2] = ovr;
        w[8] = ie;
        return w;
    endfunction

    always_comb begin
        rdData = '0;
        unique case (1'b1)
            hit_kd:  rdData[3:0] = k_data;
            hit_sd:  rdData[9:0] = s_deb;
            hit_kc:  rdData = ctrl_word(k_ready, k_ovr, k_ie);
            hit_sc:  rdData = ctrl_word(s_ready, s_ovr, s_ie);
            default: rdData = '0;
        endcase
    end

endmodule
